// File: rtl/ghash_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ghash_ctrl_pkg
// Brief    : Shared types and constants for the N-block GHASH sequencer:
//            FSM state encoding, default length-field width and the bit
//            positions of len(A)||len(C) inside the length block.
// Revision : 1.0 - initial release
// ============================================================================
package ghash_ctrl_pkg;

    // Default width of the bit-length fields carried by a descriptor.
    localparam int NB_LEN_DEFAULT = 64;

    // log2 of the GHASH block width; converts bit lengths to block counts.
    localparam int BLOCK_SHIFT = 7;

    // Field positions inside block 0 of the length word.
    localparam int LEN_AAD_LSB  = 64;
    localparam int LEN_TEXT_LSB = 0;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AAD  = 3'd1,
        ST_TEXT = 3'd2,
        ST_LEN  = 3'd3,
        ST_WAIT = 3'd4
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/ghash_ctrl_last_word.sv
`default_nettype none
// ============================================================================
// Module   : ghash_ctrl_last_word
// Brief    : Combinational helper for the last bus word of a section. From
//            the section block count it derives which trailing blocks are
//            skipped; when GHASH_CTRL_PAD_MASK_EN is defined it also builds
//            a data mask that zeroes skipped blocks and the bits below the
//            valid prefix of the final partial block. Without the macro the
//            mask is all ones (data passes unmodified).
// Revision : 1.0 - initial release
// ============================================================================
module ghash_ctrl_last_word
    import ghash_ctrl_pkg::*;
#(
    parameter int NB_BLOCK = 128,
    parameter int N_BLOCKS = 2,
    parameter int NB_DATA  = N_BLOCKS * NB_BLOCK,
    parameter int NB_LEN   = NB_LEN_DEFAULT,
    parameter int NB_CNT   = NB_LEN - BLOCK_SHIFT + 1
)(
    input  logic [NB_CNT-1:0]   i_blocks,
    input  logic [NB_LEN-1:0]   i_len,
    output logic [N_BLOCKS-1:0] o_skip,
    output logic [NB_DATA-1:0]  o_mask
);

    // Index of the last valid block within the word: (blocks-1) mod N_BLOCKS.
    localparam logic [NB_CNT-1:0] c_idx_mask = NB_CNT'(N_BLOCKS - 1);

    logic [NB_CNT-1:0] w_last_idx;

    assign w_last_idx = (i_blocks - NB_CNT'(1)) & c_idx_mask;

    generate
        for (genvar k = 0; k < N_BLOCKS; k++) begin : g_blk
            // Everything above the last valid block is skipped.
            assign o_skip[k] = (NB_CNT'(k) > w_last_idx);
        end
    endgenerate

`ifdef GHASH_CTRL_PAD_MASK_EN
    logic [BLOCK_SHIFT-1:0] w_rem;
    logic [NB_BLOCK-1:0]    w_prefix;
    logic                   w_unused_len;

    assign w_rem        = i_len[BLOCK_SHIFT-1:0];
    // Keep the top (len mod 128) bits of the final partial block.
    assign w_prefix     = ~({NB_BLOCK{1'b1}} >> w_rem);
    assign w_unused_len = ^i_len[NB_LEN-1:BLOCK_SHIFT];

    generate
        for (genvar k = 0; k < N_BLOCKS; k++) begin : g_mask
            logic [NB_BLOCK-1:0] w_blk_mask;
            // Skipped blocks vanish, the final partial block keeps its prefix.
            always_comb begin
                w_blk_mask = {NB_BLOCK{1'b1}};
                if (o_skip[k]) begin
                    w_blk_mask = '0;
                end else if ((NB_CNT'(k) == w_last_idx) && (w_rem != '0)) begin
                    w_blk_mask = w_prefix;
                end
            end
            assign o_mask[k*NB_BLOCK +: NB_BLOCK] = w_blk_mask;
        end
    endgenerate
`else
    logic w_unused_len;

    assign w_unused_len = ^i_len;
    assign o_mask       = {NB_DATA{1'b1}};
`endif

endmodule
`default_nettype wire

// File: rtl/ghash_n_blocks_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ghash_n_blocks_ctrl
// Brief    : Sequencer for the N-block KOA GHASH core. Takes one descriptor
//            (AAD/text bit lengths), pulls AAD then text words from a
//            valid/ready stream, drives core sop/valid/skip_bus, appends the
//            len(A)||len(C) block and captures the final GHASH as the tag.
//            Optional feature macro: GHASH_CTRL_PAD_MASK_EN (zero the padding
//            of each section's last word before it reaches the core).
// Revision : 1.0 - initial release
// ============================================================================
module ghash_n_blocks_ctrl
    import ghash_ctrl_pkg::*;
#(
    parameter int NB_BLOCK      = 128,
    parameter int N_BLOCKS      = 2,
    parameter int LOG2_N_BLOCKS = 1,
    parameter int NB_DATA       = N_BLOCKS * NB_BLOCK,
    parameter int NB_LEN        = NB_LEN_DEFAULT,
    parameter int CORE_LATENCY  = 0
)(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_LEN-1:0]   i_len_aad,
    input  logic [NB_LEN-1:0]   i_len_text,
    input  logic [NB_DATA-1:0]  i_data_bus,
    input  logic                i_data_valid,
    output logic                o_data_ready,
    output logic [NB_DATA-1:0]  o_core_data_bus,
    output logic [NB_BLOCK-1:0] o_core_x_initial,
    output logic                o_core_sop,
    output logic                o_core_valid,
    output logic [N_BLOCKS-1:0] o_core_skip_bus,
    input  logic [NB_BLOCK-1:0] i_core_data_y,
    output logic [NB_BLOCK-1:0] o_tag,
    output logic                o_tag_valid,
    output logic                o_busy
);

    // Block counts carry one extra bit so ceil() of the largest length fits.
    localparam int NB_CNT  = NB_LEN - BLOCK_SHIFT + 1;
    localparam int NB_WCNT = NB_LEN - BLOCK_SHIFT;
    localparam int NB_WAIT = $clog2(CORE_LATENCY + 2);

    ctrl_state_e         state_q, state_d;
    logic [NB_LEN-1:0]   len_aad_q, len_aad_d;
    logic [NB_LEN-1:0]   len_text_q, len_text_d;
    logic [NB_CNT-1:0]   blk_aad_q, blk_aad_d;
    logic [NB_CNT-1:0]   blk_text_q, blk_text_d;
    logic [NB_WCNT-1:0]  words_q, words_d;
    logic [NB_WAIT-1:0]  wait_q, wait_d;
    logic                first_q, first_d;
    logic [NB_DATA-1:0]  core_data_q, core_data_d;
    logic                core_sop_q, core_sop_d;
    logic                core_valid_q, core_valid_d;
    logic [N_BLOCKS-1:0] core_skip_q, core_skip_d;
    logic [NB_BLOCK-1:0] tag_q, tag_d;
    logic                tag_valid_q, tag_valid_d;
    logic                busy_q, busy_d;

    logic [NB_CNT-1:0]   w_blk_aad_new;
    logic [NB_CNT-1:0]   w_blk_text_new;
    logic [NB_CNT-1:0]   w_lw_blocks;
    logic [NB_LEN-1:0]   w_lw_len;
    logic [N_BLOCKS-1:0] w_lw_skip;
    logic [NB_DATA-1:0]  w_lw_mask;

    // Bus words needed for a section: ceil(blocks / N_BLOCKS).
    function automatic logic [NB_WCNT-1:0] words_of(input logic [NB_CNT-1:0] blocks);
        logic [NB_CNT-1:0] sum;
        sum = blocks + NB_CNT'(N_BLOCKS - 1);
        return NB_WCNT'(sum >> LOG2_N_BLOCKS);
    endfunction

    // ceil(len/128) for each section of the incoming descriptor.
    assign w_blk_aad_new  = NB_CNT'(i_len_aad[NB_LEN-1:BLOCK_SHIFT])
                          + NB_CNT'(|i_len_aad[BLOCK_SHIFT-1:0]);
    assign w_blk_text_new = NB_CNT'(i_len_text[NB_LEN-1:BLOCK_SHIFT])
                          + NB_CNT'(|i_len_text[BLOCK_SHIFT-1:0]);

    assign w_lw_blocks = (state_q == ST_TEXT) ? blk_text_q : blk_aad_q;
    assign w_lw_len    = (state_q == ST_TEXT) ? len_text_q : len_aad_q;

    ghash_ctrl_last_word #(
        .NB_BLOCK (NB_BLOCK),
        .N_BLOCKS (N_BLOCKS),
        .NB_DATA  (NB_DATA),
        .NB_LEN   (NB_LEN),
        .NB_CNT   (NB_CNT)
    ) u_last_word (
        .i_blocks (w_lw_blocks),
        .i_len    (w_lw_len),
        .o_skip   (w_lw_skip),
        .o_mask   (w_lw_mask)
    );

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        len_aad_d    = len_aad_q;
        len_text_d   = len_text_q;
        blk_aad_d    = blk_aad_q;
        blk_text_d   = blk_text_q;
        words_d      = words_q;
        wait_d       = wait_q;
        first_d      = first_q;
        core_data_d  = '0;
        core_sop_d   = 1'b0;
        core_valid_d = 1'b0;
        core_skip_d  = '0;
        tag_d        = tag_q;
        tag_valid_d  = 1'b0;
        busy_d       = busy_q;

        // Busy covers the tag pulse cycle, then drops.
        if (tag_valid_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start && !busy_q) begin
                    len_aad_d  = i_len_aad;
                    len_text_d = i_len_text;
                    blk_aad_d  = w_blk_aad_new;
                    blk_text_d = w_blk_text_new;
                    first_d    = 1'b1;
                    busy_d     = 1'b1;
                    if (w_blk_aad_new != '0) begin
                        state_d = ST_AAD;
                        words_d = words_of(w_blk_aad_new);
                    end else if (w_blk_text_new != '0) begin
                        state_d = ST_TEXT;
                        words_d = words_of(w_blk_text_new);
                    end else begin
                        state_d = ST_LEN;
                    end
                end
            end

            ST_AAD, ST_TEXT: begin
                if (i_data_valid) begin
                    core_valid_d = 1'b1;
                    core_sop_d   = first_q;
                    first_d      = 1'b0;
                    if (words_q == NB_WCNT'(1)) begin
                        core_data_d = i_data_bus & w_lw_mask;
                        core_skip_d = w_lw_skip;
                        if ((state_q == ST_AAD) && (blk_text_q != '0)) begin
                            state_d = ST_TEXT;
                            words_d = words_of(blk_text_q);
                        end else begin
                            state_d = ST_LEN;
                        end
                    end else begin
                        core_data_d = i_data_bus;
                        words_d     = words_q - NB_WCNT'(1);
                    end
                end
            end

            ST_LEN: begin
                core_valid_d = 1'b1;
                core_sop_d   = first_q;
                first_d      = 1'b0;
                core_data_d[LEN_AAD_LSB  +: NB_LEN] = len_aad_q;
                core_data_d[LEN_TEXT_LSB +: NB_LEN] = len_text_q;
                core_skip_d  = ~N_BLOCKS'(1);
                wait_d       = '0;
                state_d      = ST_WAIT;
            end

            ST_WAIT: begin
                if (wait_q == NB_WAIT'(CORE_LATENCY)) begin
                    tag_d       = i_core_data_y;
                    tag_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q + NB_WAIT'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial message.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            len_aad_q    <= '0;
            len_text_q   <= '0;
            blk_aad_q    <= '0;
            blk_text_q   <= '0;
            words_q      <= '0;
            wait_q       <= '0;
            first_q      <= 1'b0;
            core_data_q  <= '0;
            core_sop_q   <= 1'b0;
            core_valid_q <= 1'b0;
            core_skip_q  <= '0;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_aad_q    <= len_aad_d;
            len_text_q   <= len_text_d;
            blk_aad_q    <= blk_aad_d;
            blk_text_q   <= blk_text_d;
            words_q      <= words_d;
            wait_q       <= wait_d;
            first_q      <= first_d;
            core_data_q  <= core_data_d;
            core_sop_q   <= core_sop_d;
            core_valid_q <= core_valid_d;
            core_skip_q  <= core_skip_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign o_data_ready     = (state_q == ST_AAD) || (state_q == ST_TEXT);
    assign o_core_data_bus  = core_data_q;
    assign o_core_x_initial = '0;
    assign o_core_sop       = core_sop_q;
    assign o_core_valid     = core_valid_q;
    assign o_core_skip_bus  = core_skip_q;
    assign o_tag            = tag_q;
    assign o_tag_valid      = tag_valid_q;
    assign o_busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ghash_n_blocks_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghash_n_blocks_ctrl
// Brief    : Self-checking bench for ghash_n_blocks_ctrl with a behavioural
//            zero-latency GHASH core attached. Expected words and tags come
//            from the bench's own message construction and GF(2^128) model.
//            Honours GHASH_CTRL_PAD_MASK_EN when the build defines it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghash_n_blocks_ctrl;

    localparam int CORE_LATENCY = 0;
    localparam logic [127:0] H_KEY = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         i_reset, i_start, i_data_valid;
    logic [63:0]  i_len_aad, i_len_text;
    logic [255:0] i_data_bus;
    logic         o_data_ready, o_core_sop, o_core_valid, o_tag_valid, o_busy;
    logic [255:0] o_core_data_bus;
    logic [127:0] o_core_x_initial, o_tag, core_y, acc_q, core_t;
    logic [1:0]   o_core_skip_bus;

    always #5 clk = ~clk;

    ghash_n_blocks_ctrl #(
        .NB_BLOCK(128), .N_BLOCKS(2), .LOG2_N_BLOCKS(1), .NB_DATA(256),
        .NB_LEN(64), .CORE_LATENCY(CORE_LATENCY)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
        .i_len_aad(i_len_aad), .i_len_text(i_len_text),
        .i_data_bus(i_data_bus), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready), .o_core_data_bus(o_core_data_bus),
        .o_core_x_initial(o_core_x_initial), .o_core_sop(o_core_sop),
        .o_core_valid(o_core_valid), .o_core_skip_bus(o_core_skip_bus),
        .i_core_data_y(core_y), .o_tag(o_tag), .o_tag_valid(o_tag_valid),
        .o_busy(o_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // GF(2^128) multiply in GCM bit order.
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'hE1, 120'd0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    // Behavioural N-block core: non-skipped blocks folded in order, zero latency.
    always_comb begin
        core_t = o_core_sop ? 128'd0 : acc_q;
        for (int k = 0; k < 2; k++) begin
            if (!o_core_skip_bus[k]) core_t = gmul(core_t ^ o_core_data_bus[k*128 +: 128], H_KEY);
        end
        core_y = o_core_valid ? core_t : acc_q;
    end

    always_ff @(posedge clk) begin
        acc_q <= i_reset ? 128'd0 : core_y;
    end

    function automatic logic [127:0] mkblk(input int sec, input int idx);
        logic [31:0] a;
        a = 32'h9E37_79B9 * 32'(idx + 1) + 32'(sec);
        return {a, ~a, a ^ 32'h5A5A_A5A5, 32'hC001_0000 + 32'(idx)};
    endfunction

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic [1:0]   skip;
        bit           is_len;
    } exp_word_t;

    exp_word_t    exp_q[$];
    exp_word_t    mon_e;
    logic [255:0] in_words[$];
    logic [127:0] ref_blocks[$];
    logic [127:0] ref_tag;
    bit           first_word;
    bit           hs_prev = 1'b0;
    int           cyc = 0, start_cyc = 0, last_cyc = 0, len_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: word order/content, handshake latency, LEN and tag timing.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (hs_prev) check_eq("valid_after_hs", 256'(o_core_valid), 256'(1));
            if (o_core_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 256'(o_core_valid), 256'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("word_data", o_core_data_bus, mon_e.data);
                    check_eq("word_sop", 256'(o_core_sop), 256'(mon_e.sop));
                    check_eq("word_skip", 256'(o_core_skip_bus), 256'(mon_e.skip));
                    if (mon_e.is_len) begin
                        if (mon_e.sop) check_eq("len_after_start", 256'(cyc - start_cyc), 256'(1));
                        else           check_eq("len_after_last_word", 256'(cyc - last_cyc), 256'(1));
                        len_cyc = cyc;
                    end
                    last_cyc = cyc;
                end
            end
            if (o_tag_valid) check_eq("tag_latency", 256'(cyc - len_cyc), 256'(CORE_LATENCY + 1));
        end
        hs_prev = o_data_ready && i_data_valid && !i_reset;
    end

    task automatic build_section(input int sec, input logic [63:0] len, input bit garbage);
        int nb, nw, rem;
        nb  = int'((len + 64'd127) >> 7);
        nw  = (nb + 1) / 2;
        rem = int'(len[6:0]);
        for (int w = 0; w < nw; w++) begin
            logic [255:0] inw, expw;
            logic [1:0]   sk;
            inw = '0; expw = '0; sk = '0;
            for (int k = 0; k < 2; k++) begin
                int b;
                logic [127:0] raw, pm, clean, ib, eb;
                b = w * 2 + k;
                if (b < nb) begin
                    raw = mkblk(sec, b);
                    pm  = {128{1'b1}};
                    if ((b == nb - 1) && (rem != 0)) pm = ~({128{1'b1}} >> rem);
                    clean = raw & pm;
                    ib = garbage ? raw : clean;
`ifdef GHASH_CTRL_PAD_MASK_EN
                    eb = clean;
`else
                    eb = ib;
`endif
                    ref_blocks.push_back(eb);
                end else begin
                    sk[k] = 1'b1;
                    ib = garbage ? mkblk(sec + 8, b) : 128'd0;
`ifdef GHASH_CTRL_PAD_MASK_EN
                    eb = 128'd0;
`else
                    eb = ib;
`endif
                end
                inw[k*128 +: 128]  = ib;
                expw[k*128 +: 128] = eb;
            end
            in_words.push_back(inw);
            exp_q.push_back('{expw, first_word, sk, 1'b0});
            first_word = 1'b0;
        end
    endtask

    task automatic build_msg(input logic [63:0] la, input logic [63:0] lt, input bit garbage);
        in_words.delete();
        ref_blocks.delete();
        exp_q.delete();
        first_word = 1'b1;
        build_section(0, la, garbage);
        build_section(1, lt, garbage);
        exp_q.push_back('{{128'd0, la, lt}, first_word, 2'b10, 1'b1});
        ref_blocks.push_back({la, lt});
        ref_tag = '0;
        foreach (ref_blocks[i]) ref_tag = gmul(ref_tag ^ ref_blocks[i], H_KEY);
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic start_msg(input logic [63:0] la, input logic [63:0] lt);
        i_len_aad  = la;
        i_len_text = lt;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start   = 1'b0;
        start_cyc = cyc;
        check_eq("busy_after_start", 256'(o_busy), 256'(1));
    endtask

    task automatic send_words(input bit rnd, input int n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int guard;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                bit v;
                v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                i_data_valid = v;
                i_data_bus   = in_words[i];
                @(negedge clk);
                acc = v && o_data_ready;
                @(posedge clk); #1;
                guard++;
            end
            check_eq("word_accepted", 256'(acc), 256'(1));
        end
        i_data_valid = 1'b0;
    endtask

    task automatic finish_msg(input string name, output logic [127:0] tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!o_tag_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq({name, "_tag_valid"}, 256'(o_tag_valid), 256'(1));
        check_eq({name, "_tag"}, 256'(o_tag), 256'(ref_tag));
        check_eq({name, "_busy_in_tag_cycle"}, 256'(o_busy), 256'(1));
        tag = o_tag;
        @(negedge clk);
        check_eq({name, "_busy_clear"}, 256'(o_busy), 256'(0));
        check_eq({name, "_tag_pulse_one"}, 256'(o_tag_valid), 256'(0));
        check_eq({name, "_tag_held"}, 256'(o_tag), 256'(ref_tag));
        check_eq({name, "_words_drained"}, 256'(exp_q.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic run_msg(input string name, input logic [63:0] la, input logic [63:0] lt,
                           input bit garbage, input bit rnd, output logic [127:0] tag);
        build_msg(la, lt, garbage);
        start_msg(la, lt);
        send_words(rnd, in_words.size());
        finish_msg(name, tag);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_ready"}, 256'(o_data_ready), 256'(0));
        check_eq({name, "_core_data"}, o_core_data_bus, 256'(0));
        check_eq({name, "_core_xinit"}, 256'(o_core_x_initial), 256'(0));
        check_eq({name, "_core_ctl"}, 256'({o_core_sop, o_core_valid, o_core_skip_bus}), 256'(0));
        check_eq({name, "_tag"}, 256'(o_tag), 256'(0));
        check_eq({name, "_tag_valid"}, 256'(o_tag_valid), 256'(0));
        check_eq({name, "_busy"}, 256'(o_busy), 256'(0));
    endtask

    logic [127:0] tag1, tag_tmp, tag_clean, tag_garb, tag_abort;

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_data_valid = 1'b0;
        i_len_aad = '0; i_len_text = '0; i_data_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        i_reset = 1'b0;
        @(posedge clk); #1;

        // AAD 256 / text 512: 1 AAD word, 2 text words, LEN word.
        run_msg("a256_t512", 64'd256, 64'd512, 1'b0, 1'b0, tag1);
        check_eq("a256_t512_nonzero", 256'(tag1 != 128'd0), 256'(1));

        // Empty message: lone LEN word carries sop; GHASH of zero block is 0.
        run_msg("empty", 64'd0, 64'd0, 1'b0, 1'b0, tag_tmp);

        // Text only, 3 blocks: skip 00 then 10; sop on first text word.
        run_msg("a0_t384", 64'd0, 64'd384, 1'b0, 1'b0, tag_tmp);

        // Same as first message with a 50% stalling upstream.
        run_msg("stall", 64'd256, 64'd512, 1'b0, 1'b1, tag_tmp);
        check_eq("stall_tag_same", 256'(tag_tmp), 256'(tag1));

        // Partial blocks: clean padding versus garbage padding.
        run_msg("pad_clean", 64'd40, 64'd200, 1'b0, 1'b0, tag_clean);
        run_msg("pad_garb", 64'd40, 64'd200, 1'b1, 1'b1, tag_garb);
`ifdef GHASH_CTRL_PAD_MASK_EN
        check_eq("mask_tag_equal", 256'(tag_garb), 256'(tag_clean));
`else
        check_eq("garbage_changes_tag", 256'(tag_garb != tag_clean), 256'(1));
`endif

        // Start together with reset: reset wins, tag cleared.
        i_len_aad = 64'd128; i_len_text = 64'd128;
        i_reset = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0; i_start = 1'b0;
        check_all_zero("rst_start");
        @(posedge clk); #1;
        check_eq("rst_start_busy_later", 256'(o_busy), 256'(0));
        check_eq("rst_start_ready_later", 256'(o_data_ready), 256'(0));

        // Load a nonzero tag, then abort a message mid-TEXT.
        run_msg("pre_abort", 64'd128, 64'd0, 1'b0, 1'b0, tag_tmp);
        build_msg(64'd0, 64'd512, 1'b0);
        start_msg(64'd0, 64'd512);
        send_words(1'b0, 1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        i_reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;

        // Fresh message after the abort.
        run_msg("post_abort", 64'd0, 64'd512, 1'b0, 1'b0, tag_abort);
        run_msg("post_abort2", 64'd128, 64'd256, 1'b0, 1'b0, tag_tmp);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
